// File: rtl/queue_write_port.sv
// Write side of the two-task operand queue: storage, per-task tail pointers and occupancy counts.
// Optional write-through forwarding to rd_data is enabled by defining QUEUE_WRITE_BYPASS_EN.
module queue_write_port #(
    parameter int DATA_W = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ts,
    input  logic [DATA_W-1:0] in_data,
    input  logic              q_dir,
    input  logic              flush,
    input  logic              flush_ts,
    input  logic [PTR_W-1:0]  flush_ptr,
    input  logic              rd_ts,
    input  logic [PTR_W-1:0]  rd_addr,
    input  logic              rd_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic [PTR_W-1:0]  tail_ptr,
    output logic              full
);
    localparam int DEPTH = 2 ** PTR_W;
    localparam logic [PTR_W:0] FULL_CNT = {1'b1, {PTR_W{1'b0}}};

    logic [1:0][PTR_W:0]   count_w;
    logic [1:0][PTR_W-1:0] tail_w;
    logic [DATA_W-1:0]     mem_reg [2*DEPTH];
    logic [DATA_W-1:0]     mem_rd;
    logic                  push_fire;
    logic                  pop_fire;
    logic [PTR_W-1:0]      step;

    assign full      = (count_w[in_ts] == FULL_CNT);
    // A flush of the pushing task wins, so the producer is stalled for that cycle.
    assign in_ready  = ~full & ~(flush & (flush_ts == in_ts));
    assign push_fire = in_valid & in_ready;
    assign rd_empty  = (count_w[rd_ts] == '0);
    assign pop_fire  = rd_pop & ~rd_empty;
    assign tail_ptr  = tail_w[in_ts];
    assign step      = q_dir ? {PTR_W{1'b1}} : PTR_W'(1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_task
            logic [PTR_W:0]   count_reg;
            logic [PTR_W:0]   count_next;
            logic [PTR_W-1:0] tail_reg;
            logic [PTR_W-1:0] tail_next;
            logic             push_i;
            logic             pop_i;
            logic             flush_i;

            assign push_i  = push_fire & (in_ts == 1'(gi));
            assign pop_i   = pop_fire & (rd_ts == 1'(gi));
            assign flush_i = flush & (flush_ts == 1'(gi));

            always_comb begin
                count_next = count_reg;
                tail_next  = tail_reg;
                if (flush_i) begin
                    count_next = '0;
                    tail_next  = flush_ptr;
                end else begin
                    if (push_i && !pop_i) begin
                        count_next = count_reg + 1'b1;
                    end else if (pop_i && !push_i) begin
                        count_next = count_reg - 1'b1;
                    end
                    if (push_i) begin
                        tail_next = tail_reg + step;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    count_reg <= '0;
                    tail_reg  <= '0;
                end else begin
                    count_reg <= count_next;
                    tail_reg  <= tail_next;
                end
            end

            assign count_w[gi] = count_reg;
            assign tail_w[gi]  = tail_reg;
        end
    endgenerate

    // Storage is never reset; a push coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && push_fire) begin
            mem_reg[{in_ts, tail_w[in_ts]}] <= in_data;
        end
    end

    assign mem_rd = mem_reg[{rd_ts, rd_addr}];

`ifdef QUEUE_WRITE_BYPASS_EN
    assign rd_data = (push_fire && (in_ts == rd_ts) && (rd_addr == tail_w[in_ts])) ? in_data : mem_rd;
`else
    assign rd_data = mem_rd;
`endif

endmodule
